tile_renderer: RTL
==================

TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have: clk  in  1  pixel clock (25 MHz), sole clock domain.
REQ-002 SHALL have: rst  in  1  reset; synchronous, active-high, sampled on rising clk.
REQ-003 SHALL have: pixel_x  in  10  current column from scan generator, 0..639 valid.
REQ-004 SHALL have: pixel_y  in  10  current row from scan generator, 0..479 valid.
REQ-005 SHALL have: HS, VS  in  1 each  sync from scan generator, active-low.
REQ-006 SHALL have: video_out  in  1  high when pixel_x/pixel_y lie in the visible area.
REQ-007 SHALL have: map_we  in  1  map write request from game logic.
REQ-008 SHALL have: map_addr  in  9  cell index, row*20+col, 0..299 valid.
REQ-009 SHALL have: map_data  in  3  tile code written.
REQ-010 SHALL have: map_ready  out  1  high when a map write is accepted this cycle.
REQ-011 SHALL have: rgb  out  12  {R[3:0],G[3:0],B[3:0]} to DAC.
REQ-012 SHALL have: HS_out, VS_out  out  1 each  sync delayed to align with rgb.
REQ-013 SHALL have: frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-014 Screen SHALL be a 20x15 grid of 32x32-pixel tiles; col = pixel_x[9:5], row = pixel_y[8:5], sub = pixel_x[4:0], pixel_y[4:0].
REQ-015 Tile codes SHALL be: 0 floor, 1 wall, 2 box, 3 target, 4 box-on-target, 5 player, 6 player-on-target, 7 void.
REQ-016 Map storage SHALL be a 300x3 internal RAM, one synchronous read port, one synchronous write port, read-first on same-address collision.
REQ-017 Pipeline SHALL be 2 stages: S1 registers RAM read of row*20+col plus sub-coords and video/HS/VS; S2 registers rgb, HS_out, VS_out.
REQ-018 Latency SHALL be exactly 2 clk from pixel inputs to rgb/HS_out/VS_out, identical for all three.
REQ-019 rgb SHALL be 12'h000 when delayed video_out is 0.
REQ-020 Palette SHALL be: 0 12'h444, 1 12'h841, 2 12'hC80, 3 12'h0C0, 4 12'hFF0, 5 12'h00F, 6 12'h0CF, 7 12'h000.
REQ-021 For codes 1..6, pixels with sub_x or sub_y equal to 0 or 31 SHALL render 12'h000 (outline).
REQ-022 For codes 3, 6, pixels with sub_x and sub_y both in 12..19 SHALL render 12'hF00 (target marker).
REQ-023 FSM states SHALL be CLEAR and RUN; reset enters CLEAR.
REQ-024 CLEAR SHALL write code 7 to addresses 0..299 one per cycle via a 9-bit counter, then enter RUN after address 299 (300 cycles).
REQ-025 In CLEAR, map_ready SHALL be 0 and map_we ignored; rgb SHALL still follow REQ-019/020 from RAM contents.
REQ-026 In RUN, map_ready SHALL equal NOT video_out (writes only in blanking, tear-free).
REQ-027 A write SHALL occur iff map_we AND map_ready AND map_addr<=299; other requests SHALL be dropped without side effect.
REQ-028 frame_tick SHALL pulse for one cycle on the first cycle VS is sampled 0 after being 1.
REQ-029 Reset asserted mid-frame or mid-CLEAR SHALL restart CLEAR from address 0.

Reset
REQ-030 On rst: rgb=0, HS_out=1, VS_out=1, frame_tick=0, map_ready=0, pipeline regs=0, clear counter=0, state=CLEAR.
REQ-031 Previous-VS register SHALL reset to 1 so no spurious frame_tick follows reset.

Structure
REQ-032 Tile-code constants, palette values, grid dimensions (20, 15, 300, 32) SHALL live in a shared package used by game logic.
REQ-033 Map RAM SHALL be a separate sub-module, map_ram, inferable as block RAM.

Verification
REQ-034 Reset then 300 idle cycles -> map_ready=0 for cycles 0..299, then 1 during blanking; all cells read code 7.
REQ-035 Write code 1 at addr 21 in blanking; scan pixel (48,48) -> rgb=12'h841 exactly 2 clk later; pixel (32,32) -> 12'h000.
REQ-036 Write code 3 at addr 0; pixel (15,15) -> 12'hF00, pixel (5,5) -> 12'h0C0, pixel (0,5) -> 12'h000.
REQ-037 map_we with video_out=1, or map_addr=300 -> map_ready/RAM unchanged; subsequent readback shows old code.
REQ-038 VS 1->0 edge -> frame_tick=1 for exactly one cycle; HS_out/VS_out equal HS/VS delayed by 2 clk throughout.
REQ-039 rst pulse at clear counter=150 -> counter restarts at 0, map_ready stays 0 for 300 further cycles.

Source files
------------

// File: rtl/tile_renderer_pkg.sv
// tile_renderer_pkg
// Shared definitions for the tile renderer and the game logic that fills
// its map: grid geometry, tile codes, palette, FSM state encoding and the
// per-pixel colour function.
// No ports (package).
package tile_renderer_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int MAP_CELLS = GRID_COLS * GRID_ROWS;   // 300
    localparam int TILE_SIZE = 32;

    localparam logic [8:0] LAST_CELL = 9'(MAP_CELLS - 1);

    typedef enum logic [2:0] {
        TILE_FLOOR         = 3'd0,
        TILE_WALL          = 3'd1,
        TILE_BOX           = 3'd2,
        TILE_TARGET        = 3'd3,
        TILE_BOX_ON_TARGET = 3'd4,
        TILE_PLAYER        = 3'd5,
        TILE_PLAYER_ON_TGT = 3'd6,
        TILE_VOID          = 3'd7
    } tile_code_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [11:0] PAL_FLOOR         = 12'h444;
    localparam logic [11:0] PAL_WALL          = 12'h841;
    localparam logic [11:0] PAL_BOX           = 12'hC80;
    localparam logic [11:0] PAL_TARGET        = 12'h0C0;
    localparam logic [11:0] PAL_BOX_ON_TARGET = 12'hFF0;
    localparam logic [11:0] PAL_PLAYER        = 12'h00F;
    localparam logic [11:0] PAL_PLAYER_ON_TGT = 12'h0CF;
    localparam logic [11:0] PAL_VOID          = 12'h000;
    localparam logic [11:0] COLOR_OUTLINE     = 12'h000;
    localparam logic [11:0] COLOR_MARKER      = 12'hF00;

    // Marker square spans sub-coordinates 12..19 inclusive in both axes.
    localparam logic [4:0] MARKER_LO = 5'd12;
    localparam logic [4:0] MARKER_HI = 5'd19;

    function automatic logic [8:0] cell_index(input logic [3:0] row, input logic [4:0] col);
        return 9'(int'(row) * GRID_COLS + int'(col));
    endfunction

    function automatic logic [11:0] palette(input logic [2:0] code);
        logic [11:0] c;
        case (code)
            3'd0:    c = PAL_FLOOR;
            3'd1:    c = PAL_WALL;
            3'd2:    c = PAL_BOX;
            3'd3:    c = PAL_TARGET;
            3'd4:    c = PAL_BOX_ON_TARGET;
            3'd5:    c = PAL_PLAYER;
            3'd6:    c = PAL_PLAYER_ON_TGT;
            default: c = PAL_VOID;
        endcase
        return c;
    endfunction

    // Colour of one pixel inside a tile: outline first (codes 1..6), then
    // the target marker (codes 3 and 6), otherwise the flat palette colour.
    function automatic logic [11:0] tile_pixel(input logic [2:0] code,
                                               input logic [4:0] sub_x,
                                               input logic [4:0] sub_y);
        logic on_edge;
        logic in_marker;
        logic outlined;
        logic has_marker;
        on_edge    = (sub_x == 5'd0) || (sub_x == 5'(TILE_SIZE - 1)) ||
                     (sub_y == 5'd0) || (sub_y == 5'(TILE_SIZE - 1));
        in_marker  = (sub_x >= MARKER_LO) && (sub_x <= MARKER_HI) &&
                     (sub_y >= MARKER_LO) && (sub_y <= MARKER_HI);
        outlined   = (code != TILE_FLOOR) && (code != TILE_VOID);
        has_marker = (code == TILE_TARGET) || (code == TILE_PLAYER_ON_TGT);
        if (outlined && on_edge)
            return COLOR_OUTLINE;
        else if (has_marker && in_marker)
            return COLOR_MARKER;
        else
            return palette(code);
    endfunction

endpackage

// File: rtl/tile_renderer_map_ram.sv
// map_ram
// 300 x 3-bit tile map. One synchronous write port, one synchronous read
// port; a read and write to the same address in one cycle returns the old
// contents. Reads beyond the last cell return the void code.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears rdata only)
//   we/waddr/wdata  write port
//   raddr/rdata     read port, rdata valid one clock after raddr
module map_ram
    import tile_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [8:0] waddr,
    input  logic [2:0] wdata,
    input  logic [8:0] raddr,
    output logic [2:0] rdata
);

    logic [2:0] mem [0:MAP_CELLS-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= 3'd0;
        else if (raddr <= LAST_CELL)
            rdata <= mem[raddr];
        else
            rdata <= TILE_VOID;
    end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer
// Draws a 20x15 grid of 32x32 tiles from an internal map RAM. After reset
// the map is filled with the void code (CLEAR), then game-logic writes are
// accepted only during blanking (RUN). Two-stage pipeline: S1 = RAM read
// plus delayed sub-coords/video/sync, S2 = rgb and delayed sync.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pixel_x, pixel_y    scan position
//   HS, VS              active-low sync in
//   video_out           scan position is visible
//   map_we/addr/data    map write request
//   map_ready           write accepted this cycle
//   rgb                 {R,G,B} 4 bits each, 2 clk after pixel inputs
//   HS_out, VS_out      sync delayed to match rgb
//   frame_tick          one-cycle pulse per VS falling edge
//   fsm_state           current FSM state (0 CLEAR, 1 RUN)
module tile_renderer
    import tile_renderer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        HS,
    input  logic        VS,
    input  logic        video_out,
    input  logic        map_we,
    input  logic [8:0]  map_addr,
    input  logic [2:0]  map_data,
    output logic        map_ready,
    output logic [11:0] rgb,
    output logic        HS_out,
    output logic        VS_out,
    output logic        frame_tick,
    output logic        fsm_state
);

    state_t     state, next_state;
    logic [8:0] clr_cnt;

    logic       ram_we;
    logic [8:0] ram_waddr;
    logic [2:0] ram_wdata;
    logic [8:0] ram_raddr;
    logic [2:0] tile_code;

    logic [4:0] sub_x_q, sub_y_q;
    logic       video_q, hs_q, vs_q;
    logic       vs_prev;

    // Rows 16..31 do not exist; steer them to an out-of-range address.
    assign ram_raddr = pixel_y[9] ? 9'h1FF : cell_index(pixel_y[8:5], pixel_x[9:5]);

    map_ram u_map_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (tile_code)
    );

    // State register and clear counter. The counter only advances in
    // CLEAR; reset is the only way back into CLEAR, and it zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= 9'd0;
        end else begin
            state <= next_state;
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + 9'd1;
        end
    end

    always_comb begin
        next_state = state;
        map_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = map_addr;
        ram_wdata  = map_data;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = TILE_VOID;
                if (clr_cnt == LAST_CELL)
                    next_state = ST_RUN;
            end
            ST_RUN: begin
                // Writes only in blanking so a frame never shows a half-updated map.
                map_ready = !video_out && !rst;
                ram_we    = map_we && map_ready && (map_addr <= LAST_CELL);
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    assign fsm_state = (state == ST_RUN);

    // Stage 1 side-band (the RAM output register holds the tile code).
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x_q <= 5'd0;
            sub_y_q <= 5'd0;
            video_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            sub_x_q <= pixel_x[4:0];
            sub_y_q <= pixel_y[4:0];
            video_q <= video_out;
            hs_q    <= HS;
            vs_q    <= VS;
        end
    end

    // Stage 2 outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb    <= 12'h000;
            HS_out <= 1'b1;
            VS_out <= 1'b1;
        end else begin
            rgb    <= video_q ? tile_pixel(tile_code, sub_x_q, sub_y_q) : 12'h000;
            HS_out <= hs_q;
            VS_out <= vs_q;
        end
    end

    // vs_prev resets high so a VS held low through reset does not tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_prev    <= VS;
            frame_tick <= vs_prev && !VS;
        end
    end

endmodule
